// File: rtl/rx_packet_controller_if.sv
// rx_packet_controller_if: signal bundle between the packet controller, the
// serial byte receiver and the two player requesters.
//   rx_ready / rx_data  receiver byte-done pulse and the byte (valid one cycle later)
//   rx_reset            receiver reset pulse issued on an inter-byte timeout
//   pN_cmd/valid/ack    per-player command valid/ack handshake
//   err_count           saturating protocol error count
//   busy                controller is inside a packet
// Modport master is the controller; slave is the receiver / game-logic side.
interface rx_packet_controller_if #(
    parameter int unsigned ERR_W = 8
);
    logic             rx_ready;
    logic [7:0]       rx_data;
    logic             rx_reset;
    logic [7:0]       p1_cmd;
    logic             p1_valid;
    logic             p1_ack;
    logic [7:0]       p2_cmd;
    logic             p2_valid;
    logic             p2_ack;
    logic [ERR_W-1:0] err_count;
    logic             busy;

    modport master (
        input  rx_ready, rx_data, p1_ack, p2_ack,
        output rx_reset, p1_cmd, p1_valid, p2_cmd, p2_valid, err_count, busy
    );

    modport slave (
        output rx_ready, rx_data, p1_ack, p2_ack,
        input  rx_reset, p1_cmd, p1_valid, p2_cmd, p2_valid, err_count, busy
    );
endinterface

// File: rtl/rx_packet_controller.sv
// rx_packet_controller: assembles receiver bytes into paddle-command packets
// (HEADER, ID, CMD[, SUM]) and hands each command to player 1 or player 2
// over a valid/ack handshake. Inter-byte timeouts resynchronise the receiver.
// Ports:
//   bounderClock  baud-rate clock, posedge
//   reset         asynchronous, active-high
//   bus           rx_packet_controller_if.master (receiver, players, status)
// Optional feature: define RX_PKT_CHECKSUM_EN for 4-byte packets whose last
// byte must equal HEADER^ID^CMD; undefined gives 3-byte packets.
module rx_packet_controller #(
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter logic [15:0] TIMEOUT = 16'd40,
    parameter int unsigned ERR_W   = 8
) (
    input  logic                  bounderClock,
    input  logic                  reset,
    rx_packet_controller_if.master bus
);
    localparam logic [7:0] ID_P1 = 8'h01;
    localparam logic [7:0] ID_P2 = 8'h02;

    typedef enum logic [2:0] {
        HUNT,
        GET_ID,
        GET_CMD,
`ifdef RX_PKT_CHECKSUM_EN
        GET_SUM,
`endif
        DISPATCH
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             rdy_d;
    logic [15:0]      timer;
    logic             to_p2;
    logic [7:0]       cmd_q;
    logic             rx_reset_q;
    logic [7:0]       p1_cmd_q;
    logic             p1_valid_q;
    logic [7:0]       p2_cmd_q;
    logic             p2_valid_q;
    logic [ERR_W-1:0] err_q;
    logic             busy_q;

    logic             byte_c;
    logic             in_get_c;
    logic             timeout_c;
    logic             err_c;
    logic             latch_id_c;
    logic             latch_cmd_c;
    logic             load1_c;
    logic             load2_c;

    // The byte is presented one cycle after the receiver strobe; DISPATCH never takes one.
    assign byte_c    = rdy_d && (state != DISPATCH);
    assign in_get_c  = (state != HUNT) && (state != DISPATCH);
    assign timeout_c = in_get_c && (timer == TIMEOUT - 16'd1);

    // State register
    always_ff @(posedge bounderClock or posedge reset) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-cycle strobes; a timeout overrides any byte in the same cycle.
    always_comb begin
        next_state  = state;
        err_c       = 1'b0;
        latch_id_c  = 1'b0;
        latch_cmd_c = 1'b0;
        load1_c     = 1'b0;
        load2_c     = 1'b0;
        if (timeout_c) begin
            next_state = HUNT;
            err_c      = 1'b1;
        end else begin
            case (state)
                HUNT: begin
                    if (byte_c && (bus.rx_data == HEADER)) next_state = GET_ID;
                end
                GET_ID: begin
                    // A repeated HEADER keeps us waiting for the ID (resync).
                    if (byte_c && (bus.rx_data != HEADER)) begin
                        if ((bus.rx_data == ID_P1) || (bus.rx_data == ID_P2)) begin
                            latch_id_c = 1'b1;
                            next_state = GET_CMD;
                        end else begin
                            err_c      = 1'b1;
                            next_state = HUNT;
                        end
                    end
                end
                GET_CMD: begin
                    if (byte_c) begin
                        latch_cmd_c = 1'b1;
`ifdef RX_PKT_CHECKSUM_EN
                        next_state  = GET_SUM;
`else
                        next_state  = DISPATCH;
`endif
                    end
                end
`ifdef RX_PKT_CHECKSUM_EN
                GET_SUM: begin
                    if (byte_c) begin
                        if (bus.rx_data == (HEADER ^ (to_p2 ? ID_P2 : ID_P1) ^ cmd_q)) begin
                            next_state = DISPATCH;
                        end else begin
                            err_c      = 1'b1;
                            next_state = HUNT;
                        end
                    end
                end
`endif
                DISPATCH: begin
                    // A slot is free if empty or being consumed on this very edge.
                    next_state = HUNT;
                    if (!to_p2) begin
                        if (!p1_valid_q || bus.p1_ack) load1_c = 1'b1;
                        else                           err_c   = 1'b1;
                    end else begin
                        if (!p2_valid_q || bus.p2_ack) load2_c = 1'b1;
                        else                           err_c   = 1'b1;
                    end
                end
                default: next_state = HUNT;
            endcase
        end
    end

    // Datapath, timer and registered outputs
    always_ff @(posedge bounderClock or posedge reset) begin
        if (reset) begin
            rdy_d      <= 1'b0;
            timer      <= '0;
            to_p2      <= 1'b0;
            cmd_q      <= '0;
            rx_reset_q <= 1'b0;
            p1_cmd_q   <= '0;
            p1_valid_q <= 1'b0;
            p2_cmd_q   <= '0;
            p2_valid_q <= 1'b0;
            err_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            rdy_d      <= bus.rx_ready;
            rx_reset_q <= timeout_c;
            busy_q     <= (next_state != HUNT);

            if (in_get_c && !timeout_c && !byte_c) timer <= timer + 16'd1;
            else                                   timer <= '0;

            if (latch_id_c)  to_p2 <= (bus.rx_data == ID_P2);
            if (latch_cmd_c) cmd_q <= bus.rx_data;

            if (load1_c) begin
                p1_cmd_q   <= cmd_q;
                p1_valid_q <= 1'b1;
            end else if (bus.p1_ack) begin
                p1_valid_q <= 1'b0;
            end

            if (load2_c) begin
                p2_cmd_q   <= cmd_q;
                p2_valid_q <= 1'b1;
            end else if (bus.p2_ack) begin
                p2_valid_q <= 1'b0;
            end

            if (err_c && (err_q != {ERR_W{1'b1}})) err_q <= err_q + ERR_W'(1);
        end
    end

    assign bus.rx_reset  = rx_reset_q;
    assign bus.p1_cmd    = p1_cmd_q;
    assign bus.p1_valid  = p1_valid_q;
    assign bus.p2_cmd    = p2_cmd_q;
    assign bus.p2_valid  = p2_valid_q;
    assign bus.err_count = err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_rx_packet_controller.sv
// tb_rx_packet_controller: scoreboard bench for rx_packet_controller.
// Directed packets cover latency, overflow, resync, timeout, checksum,
// saturation and async reset; a random byte stream is parsed by a
// packet-level model that predicts commands per player and the error count.
module tb_rx_packet_controller;
    localparam logic [7:0] HDR = 8'hA5;
    localparam int         TMO = 40;
`ifdef RX_PKT_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic a_ack1, a_ack2, m_ack1, m_ack2;
    bit   auto1, auto2;

    int checks = 0;
    int errors = 0;
    int m_err  = 0;
    logic [7:0] exp1 [$];
    logic [7:0] exp2 [$];
    logic [7:0] part [$];

    rx_packet_controller_if #(.ERR_W(8)) bus ();

    rx_packet_controller #(
        .HEADER (HDR),
        .TIMEOUT(16'(TMO)),
        .ERR_W  (8)
    ) dut (
        .bounderClock(clk),
        .reset       (rst),
        .bus         (bus)
    );

    assign bus.p1_ack = a_ack1 | m_ack1;
    assign bus.p2_ack = a_ack2 | m_ack2;

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: every consumed command (valid & ack at the coming edge) is popped and compared.
    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.p1_valid && bus.p1_ack) begin
                if (exp1.size() == 0) check("p1_unexpected_cmd", {24'd0, bus.p1_cmd}, 32'hFFFF_FFFF);
                else begin e = exp1.pop_front(); check("p1_cmd", {24'd0, bus.p1_cmd}, {24'd0, e}); end
            end
            if (!rst && bus.p2_valid && bus.p2_ack) begin
                if (exp2.size() == 0) check("p2_unexpected_cmd", {24'd0, bus.p2_cmd}, 32'hFFFF_FFFF);
                else begin e = exp2.pop_front(); check("p2_cmd", {24'd0, bus.p2_cmd}, {24'd0, e}); end
            end
        end
    endtask

    // Auto consumers ack within 0..2 cycles of seeing valid.
    task automatic consumer1();
        int w = 0;
        forever begin
            @(posedge clk); #2;
            if (a_ack1) a_ack1 = 1'b0;
            else if (auto1 && bus.p1_valid) begin
                if (w == 0) begin a_ack1 = 1'b1; w = $urandom_range(0, 2); end
                else w--;
            end
        end
    endtask

    task automatic consumer2();
        int w = 0;
        forever begin
            @(posedge clk); #2;
            if (a_ack2) a_ack2 = 1'b0;
            else if (auto2 && bus.p2_valid) begin
                if (w == 0) begin a_ack2 = 1'b1; w = $urandom_range(0, 2); end
                else w--;
            end
        end
    endtask

    // One receiver byte: strobe, then the data the following cycle; returns at the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #2;
        bus.rx_ready = 1'b1;
        bus.rx_data  = 8'($urandom);
        @(posedge clk); #2;
        bus.rx_ready = 1'b0;
        bus.rx_data  = b;
        @(posedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] id, input logic [7:0] cmd);
        send_byte(HDR);
        send_byte(id);
        send_byte(cmd);
        if (CHK) send_byte(HDR ^ id ^ cmd);
    endtask

    task automatic bump();
        if (m_err < 255) m_err++;
    endtask

    // Packet-level reference: collects bytes of a candidate packet and decides its fate.
    task automatic model_byte(input logic [7:0] b);
        case (part.size())
            0: if (b == HDR) part.push_back(b);
            1: begin
                if (b == 8'h01 || b == 8'h02) part.push_back(b);
                else if (b != HDR) begin bump(); part.delete(); end
            end
            2: begin
                if (CHK) part.push_back(b);
                else begin
                    if (part[1] == 8'h01) exp1.push_back(b); else exp2.push_back(b);
                    part.delete();
                end
            end
            default: begin
                if (b == (part[0] ^ part[1] ^ part[2])) begin
                    if (part[1] == 8'h01) exp1.push_back(part[2]); else exp2.push_back(part[2]);
                end else bump();
                part.delete();
            end
        endcase
    endtask

    task automatic msend(input logic [7:0] b, input int gap);
        model_byte(b);
        send_byte(b);
        repeat (gap) @(posedge clk);
    endtask

    task automatic mpkt(input logic [7:0] id, input logic [7:0] cmd);
        msend(HDR, 0);
        msend(id, 0);
        msend(cmd, 0);
        if (CHK) msend(HDR ^ id ^ cmd, 0);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp1.size() != 0 || exp2.size() != 0 || bus.p1_valid || bus.p2_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_p1_pending"}, exp1.size(), 0);
        check({name, "_p2_pending"}, exp2.size(), 0);
        check({name, "_p1_valid_idle"}, {31'd0, bus.p1_valid}, 0);
        check({name, "_p2_valid_idle"}, {31'd0, bus.p2_valid}, 0);
    endtask

    initial begin
        int pulses, pos, kind;
        logic [7:0] id, cmd, b;
        rst = 1'b1;
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        a_ack1 = 1'b0; a_ack2 = 1'b0; m_ack1 = 1'b0; m_ack2 = 1'b0;
        auto1 = 1'b0; auto2 = 1'b0;
        fork
            monitor();
            consumer1();
            consumer2();
        join_none
        repeat (2) @(negedge clk);
        check("rst_p1_valid", {31'd0, bus.p1_valid}, 0);
        check("rst_p2_valid", {31'd0, bus.p2_valid}, 0);
        check("rst_err", {24'd0, bus.err_count}, 0);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_rx_reset", {31'd0, bus.rx_reset}, 0);
        check("rst_p1_cmd", {24'd0, bus.p1_cmd}, 0);
        rst = 1'b0;

        // Basic packet and 2-cycle latency
        send_pkt(8'h01, 8'h3C);
        @(negedge clk);
        check("lat_p1_valid_dispatch", {31'd0, bus.p1_valid}, 0);
        @(negedge clk);
        check("lat_p1_valid", {31'd0, bus.p1_valid}, 1);
        check("lat_p1_cmd", {24'd0, bus.p1_cmd}, 32'h3C);
        check("lat_p2_valid", {31'd0, bus.p2_valid}, 0);
        check("lat_err", {24'd0, bus.err_count}, 0);
        exp1.push_back(8'h3C);
        auto1 = 1'b1;

        // Overflow, then ack in the DISPATCH cycle
        send_pkt(8'h02, 8'h11);
        settle();
        check("ovf_first_cmd", {24'd0, bus.p2_cmd}, 32'h11);
        send_pkt(8'h02, 8'h22);
        bump();
        settle();
        check("ovf_kept_cmd", {24'd0, bus.p2_cmd}, 32'h11);
        check("ovf_valid", {31'd0, bus.p2_valid}, 1);
        check("ovf_err", {24'd0, bus.err_count}, m_err);
        exp2.push_back(8'h11);
        exp2.push_back(8'h33);
        send_pkt(8'h02, 8'h33);
        #1 m_ack2 = 1'b1;
        @(posedge clk); #1 m_ack2 = 1'b0;
        @(negedge clk);
        check("reload_valid", {31'd0, bus.p2_valid}, 1);
        check("reload_cmd", {24'd0, bus.p2_cmd}, 32'h33);
        check("reload_err", {24'd0, bus.err_count}, m_err);
        auto2 = 1'b1;
        drain("dir1");

        // Bad id, then header resync
        msend(HDR, 0);
        msend(8'h07, 0);
        settle();
        check("badid_err", {24'd0, bus.err_count}, m_err);
        check("badid_busy", {31'd0, bus.busy}, 0);
        check("badid_p1_valid", {31'd0, bus.p1_valid}, 0);
        check("badid_p2_valid", {31'd0, bus.p2_valid}, 0);
        msend(HDR, 0);
        mpkt(8'h02, 8'h44);
        drain("resync");

        // Inter-byte timeout
        send_byte(HDR);
        send_byte(8'h01);
        pulses = 0;
        pos = -1;
        for (int n = 0; n < TMO + 5; n++) begin
            @(negedge clk);
            if (n == 0) check("tmo_busy_before", {31'd0, bus.busy}, 1);
            if (bus.rx_reset) begin pulses++; if (pos < 0) pos = n; end
        end
        bump();
        check("tmo_pulses", pulses, 1);
        check("tmo_position", pos, TMO);
        check("tmo_busy_after", {31'd0, bus.busy}, 0);
        check("tmo_err", {24'd0, bus.err_count}, m_err);
        mpkt(8'h02, 8'h5A);
        drain("post_tmo");

`ifdef RX_PKT_CHECKSUM_EN
        msend(HDR, 0);
        msend(8'h01, 0);
        msend(8'h3C, 0);
        msend(8'h00, 0);
        settle();
        check("sum_err", {24'd0, bus.err_count}, m_err);
        check("sum_no_valid", {31'd0, bus.p1_valid}, 0);
`endif

        // Random stream checked by the packet-level model
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            id   = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
            cmd  = 8'($urandom);
            if (kind <= 5) begin
                mpkt(id, cmd);
            end else if (kind == 6) begin
                do b = 8'($urandom); while (b == 8'h01 || b == 8'h02 || b == HDR);
                msend(HDR, 0);
                msend(b, $urandom_range(0, 3));
            end else if (kind == 7) begin
                do b = 8'($urandom); while (b == HDR);
                msend(b, $urandom_range(0, 3));
            end else if (kind == 8) begin
                msend(HDR, $urandom_range(0, 3));
                mpkt(id, cmd);
            end else begin
                msend(HDR, 0);
                msend(id, 0);
                msend(cmd, 0);
                msend(CHK ? (HDR ^ id ^ cmd ^ 8'($urandom_range(1, 255))) : 8'($urandom), 0);
            end
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end
        drain("random");
        check("random_err", {24'd0, bus.err_count}, m_err);

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            msend(HDR, 0);
            msend(8'h07, 0);
        end
        settle();
        check("sat_err", {24'd0, bus.err_count}, 32'hFF);

        // Async reset mid-packet
        auto1 = 1'b0;
        send_pkt(8'h01, 8'h77);
        settle();
        check("prerst_valid", {31'd0, bus.p1_valid}, 1);
        send_byte(HDR);
        send_byte(8'h01);
        #3 rst = 1'b1;
        #1;
        check("arst_p1_valid", {31'd0, bus.p1_valid}, 0);
        check("arst_p1_cmd", {24'd0, bus.p1_cmd}, 0);
        check("arst_err", {24'd0, bus.err_count}, 0);
        check("arst_busy", {31'd0, bus.busy}, 0);
        exp1.delete();
        exp2.delete();
        part.delete();
        m_err = 0;
        @(negedge clk);
        rst = 1'b0;
        auto1 = 1'b1;
        mpkt(8'h01, 8'h66);
        drain("post_rst");
        check("post_rst_err", {24'd0, bus.err_count}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
